// File: rtl/matrix_result_serializer.sv
// Captures the 3x3 multiplier result and cycle count on a rising done edge and
// streams them out as a header-prefixed, big-endian byte frame over valid/ready.
module matrix_result_serializer #(
    parameter int          N_ELEM      = 9,
    parameter int          DATA_W      = 16,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5,
    parameter bit          SEND_CYCLES = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic [DATA_W-1:0] c0,
    input  logic [DATA_W-1:0] c1,
    input  logic [DATA_W-1:0] c2,
    input  logic [DATA_W-1:0] c3,
    input  logic [DATA_W-1:0] c4,
    input  logic [DATA_W-1:0] c5,
    input  logic [DATA_W-1:0] c6,
    input  logic [DATA_W-1:0] c7,
    input  logic [DATA_W-1:0] c8,
    input  logic [DATA_W-1:0] cycle_count,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int         FRAME_LEN = 1 + 2 * N_ELEM + (SEND_CYCLES ? 2 : 0);
    localparam logic [4:0] LAST_IDX  = 5'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

    state_t                     state_q, state_d;
    logic [4:0]                 idx_q, idx_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic                       tx_valid_q, tx_valid_d;
    logic                       done_q;
    logic                       start;
    logic                       snap_en;
    logic [N_ELEM*DATA_W-1:0]   elems_q;
    logic [DATA_W-1:0]          cc_q;
    logic [7:0]                 nxt_byte;

    // Byte idx of the frame: header, then each element high byte first,
    // then optionally the cycle count.
    function automatic logic [7:0] frame_byte(input logic [4:0] idx,
                                              input logic [N_ELEM*DATA_W-1:0] elems,
                                              input logic [DATA_W-1:0] cc);
        int k;
        logic [DATA_W-1:0] w;
        k = int'(idx) - 1;
        w = cc;
        if (idx == 5'd0) begin
            return HDR_BYTE;
        end
        if (k < 2 * N_ELEM) begin
            w = elems[(k / 2) * DATA_W +: DATA_W];
        end else begin
            k = k - 2 * N_ELEM;
        end
        return k[0] ? w[7:0] : w[15:8];
    endfunction

    assign start    = done && !done_q && (state_q == IDLE);
    assign nxt_byte = frame_byte(idx_q + 5'd1, elems_q, cc_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        snap_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    snap_en = 1'b1;
                end
            end
            LOAD: begin
                state_d    = SEND;
                idx_d      = 5'd0;
                tx_data_d  = HDR_BYTE;
                tx_valid_d = 1'b1;
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = FIN;
                        idx_d      = 5'd0;
                        tx_data_d  = 8'd0;
                        tx_valid_d = 1'b0;
                    end else begin
                        idx_d     = idx_q + 5'd1;
                        tx_data_d = nxt_byte;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 5'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done;
        end
    end

    // Snapshot is pure data; it is only meaningful once a frame has started.
    always_ff @(posedge clk) begin
        if (snap_en) begin
            elems_q <= {c8, c7, c6, c5, c4, c3, c2, c1, c0};
            cc_q    <= cycle_count;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (state_q == LOAD) || (state_q == SEND);
    assign frame_done = (state_q == FIN);

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Scoreboard bench: stimulus pushes whole expected frames, a negedge monitor
// pops and compares each accepted byte for a 21-byte and a 19-byte build.
module tb_matrix_result_serializer;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        rst, done, rdy;
    logic [15:0] c [9];
    logic [15:0] cc;
    logic [7:0]  d1, d0;
    logic        v1, v0, b1, b0, fd1, fd0;

    logic [7:0]  od [2];
    logic        ov [2], ob [2], ofd [2], ordy [2];
    assign od[0] = d0;  assign od[1] = d1;
    assign ov[0] = v0;  assign ov[1] = v1;
    assign ob[0] = b0;  assign ob[1] = b1;
    assign ofd[0] = fd0; assign ofd[1] = fd1;
    assign ordy[0] = 1'b1; assign ordy[1] = rdy;

    always #5 clk = ~clk;

    matrix_result_serializer #(.SEND_CYCLES(1'b1)) dut1 (
        .clk(clk), .rst(rst), .done(done),
        .c0(c[0]), .c1(c[1]), .c2(c[2]), .c3(c[3]), .c4(c[4]),
        .c5(c[5]), .c6(c[6]), .c7(c[7]), .c8(c[8]), .cycle_count(cc),
        .tx_data(d1), .tx_valid(v1), .tx_ready(rdy), .busy(b1), .frame_done(fd1));

    matrix_result_serializer #(.SEND_CYCLES(1'b0)) dut0 (
        .clk(clk), .rst(rst), .done(done),
        .c0(c[0]), .c1(c[1]), .c2(c[2]), .c3(c[3]), .c4(c[4]),
        .c5(c[5]), .c6(c[6]), .c7(c[7]), .c8(c[8]), .cycle_count(cc),
        .tx_data(d0), .tx_valid(v0), .tx_ready(1'b1), .busy(b0), .frame_done(fd0));

    logic [7:0] mem [2][256];
    int  head [2], tail [2], fbase [2], lcnt [2];
    bit  active [2], wfirst [2], pend [2], after [2];
    int  total = 0, bad = 0;
    int  mode = 0, stall_left = 0;
    bit  stall_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic put(input int k, input logic [7:0] b);
        mem[k][tail[k] % 256] = b;
        tail[k]++;
    endtask

    // Reference: a frame is header, each element big-endian, optional count.
    task automatic push_frames();
        for (int k = 0; k < 2; k++) begin
            if (!active[k]) begin
                fbase[k] = tail[k];
                put(k, HDR);
                for (int i = 0; i < 9; i++) begin
                    put(k, 8'(c[i] / 256));
                    put(k, 8'(c[i] % 256));
                end
                if (k == 1) begin
                    put(k, 8'(cc / 256));
                    put(k, 8'(cc % 256));
                end
                active[k] = 1'b1;
                wfirst[k] = 1'b1;
                lcnt[k]   = 0;
            end
        end
    endtask

    task automatic flush();
        for (int k = 0; k < 2; k++) begin
            head[k] = tail[k];
            active[k] = 1'b0; wfirst[k] = 1'b0; pend[k] = 1'b0; after[k] = 1'b0;
        end
    endtask

    task automatic raise_done();
        @(posedge clk); #1;
        done = 1'b1;
        stall_done = 1'b0;
        push_frames();
    endtask

    task automatic pulse_done();
        raise_done();
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((active[0] || active[1]) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (active[0] || active[1]) begin
            check("idle_timeout", 0, 1);
            flush();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic load_ref();
        c[0] = 16'd30;  c[1] = 16'd24;  c[2] = 16'd18;
        c[3] = 16'd84;  c[4] = 16'd69;  c[5] = 16'd54;
        c[6] = 16'd138; c[7] = 16'd114; c[8] = 16'd90;
        cc   = 16'h0051;
    endtask

    always @(posedge clk) begin
        #1;
        if (mode == 0) begin
            rdy = 1'b1;
        end else if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end else if (!stall_done && active[1] && (head[1] - fbase[1] == 7)) begin
            rdy = 1'b0;
            stall_left = 4;
            stall_done = 1'b1;
        end else begin
            rdy = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (pend[k]) begin
                    check($sformatf("frame_done dut%0d", k), int'(ofd[k]), 1);
                    check($sformatf("fin_valid dut%0d", k), int'(ov[k]), 0);
                    check($sformatf("fin_busy dut%0d", k), int'(ob[k]), 0);
                    pend[k] = 1'b0; active[k] = 1'b0; after[k] = 1'b1;
                end else begin
                    if (after[k]) begin
                        check($sformatf("frame_done_width dut%0d", k), int'(ofd[k]), 0);
                        after[k] = 1'b0;
                    end else if (ofd[k]) begin
                        check($sformatf("frame_done_spurious dut%0d", k), 1, 0);
                    end
                    if (wfirst[k]) begin
                        lcnt[k]++;
                        if (lcnt[k] == 2) begin
                            check($sformatf("load_busy dut%0d", k), int'(ob[k]), 1);
                            check($sformatf("load_valid dut%0d", k), int'(ov[k]), 0);
                        end
                        if (ov[k]) begin
                            check($sformatf("first_latency dut%0d", k), lcnt[k], 3);
                            wfirst[k] = 1'b0;
                        end else if (lcnt[k] > 6) begin
                            check($sformatf("first_timeout dut%0d", k), 0, 1);
                            wfirst[k] = 1'b0; active[k] = 1'b0; head[k] = tail[k];
                        end
                    end
                    if (ov[k]) begin
                        if (head[k] == tail[k]) begin
                            check($sformatf("extra_byte dut%0d", k), int'(od[k]), -1);
                        end else begin
                            check($sformatf("byte[%0d] dut%0d", head[k] - fbase[k], k),
                                  int'(od[k]), int'(mem[k][head[k] % 256]));
                            check($sformatf("busy dut%0d", k), int'(ob[k]), 1);
                            if (ordy[k]) begin
                                head[k]++;
                                if (head[k] == tail[k]) pend[k] = 1'b1;
                            end
                        end
                    end else if (active[k] && !wfirst[k] && head[k] != tail[k]) begin
                        check($sformatf("valid_drop dut%0d", k), 0, 1);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; done = 1'b0; rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            head[k] = 0; tail[k] = 0; fbase[k] = 0; lcnt[k] = 0;
        end
        flush();
        load_ref();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_data dut%0d", k), int'(od[k]), 0);
            check($sformatf("rst_valid dut%0d", k), int'(ov[k]), 0);
            check($sformatf("rst_busy dut%0d", k), int'(ob[k]), 0);
            check($sformatf("rst_frame_done dut%0d", k), int'(ofd[k]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Reference frame, always ready.
        mode = 0;
        pulse_done();
        wait_idle();

        // Same frame with random backpressure and a long stall on byte 7.
        mode = 1;
        pulse_done();
        wait_idle();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 9; i++) c[i] = 16'($urandom);
            cc = 16'($urandom);
            pulse_done();
            wait_idle();
        end

        // Level-held done yields one frame; a fresh edge yields another.
        load_ref();
        raise_done();
        repeat (100) @(posedge clk);
        #1 done = 1'b0;
        wait_idle();
        pulse_done();
        wait_idle();

        // Input change and done re-pulse mid-frame must not disturb it.
        pulse_done();
        repeat (4) @(posedge clk);
        #1 c[0] = 16'hFFFF;
        pulse_done();
        wait_idle();
        c[0] = 16'd30;

        // Reset mid-frame, then a full frame from the header.
        mode = 0;
        pulse_done();
        begin
            int n;
            n = 0;
            while (head[1] - fbase[1] < 10 && n < 100) begin
                @(posedge clk);
                n++;
            end
            if (head[1] - fbase[1] < 10) check("reach_byte10", 0, 1);
        end
        #1 rst = 1'b1;
        flush();
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("abort_valid dut%0d", k), int'(ov[k]), 0);
            check($sformatf("abort_busy dut%0d", k), int'(ob[k]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        pulse_done();
        wait_idle();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Drain side of the 3x3 serial multiplier: snapshots result matrix c0..c8 and cycle_count when multiplier done rises, then streams them out as a byte frame over a valid/ready handshake.
- Feeds the byte-oriented transmit path (UART TX or host capture) that sits downstream of serial_matrix_multiplication.

Parameters:
- N_ELEM, 9, number of result elements per frame (fixed 3x3)
- DATA_W, 16, width of each result element and of cycle_count
- HDR_BYTE, 8'hA5, frame start marker sent first
- SEND_CYCLES, 1, 1 = append cycle_count (2 bytes) after elements; 0 = omit

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- done  in  1  multiplier done (level); internally rising-edge detected
- c0..c8  in  16 each  result elements, row-major
- cycle_count  in  16  multiplier cycle count
- tx_data  out  8  current frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts byte when high with tx_valid
- busy  out  1  high from snapshot until last byte accepted
- frame_done  out  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset (rst=1 at clock edge): tx_data=0, tx_valid=0, busy=0, frame_done=0, byte index=0, done edge register=0, state=IDLE. Reset mid-frame aborts; tx_valid low from next cycle, no partial resume.
- Start condition: done=1 this cycle and done=0 previous cycle (registered edge detect), while state=IDLE. A done held high triggers exactly once. Rising edges while busy are ignored (no queueing).
- States: IDLE -> LOAD on start; LOAD -> SEND (1 cycle, snapshot already taken); SEND -> FIN after last byte handshake; FIN -> IDLE (frame_done=1 in FIN only).
- Snapshot: c0..c8 and cycle_count registered at the start edge; later input changes do not affect the frame.
- Latency: start sampled at edge k; busy=1 after edge k; tx_valid=1 with HDR_BYTE after edge k+1.
- Frame order: HDR_BYTE, then for i=0..8 c_i[15:8], c_i[7:0], then (if SEND_CYCLES) cycle_count[15:8], cycle_count[7:0]. Length 21 bytes (SEND_CYCLES=1) or 19 (SEND_CYCLES=0).
- Handshake: a byte transfers on an edge with tx_valid=1 and tx_ready=1. While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. tx_valid never drops mid-frame except on reset. Continuous tx_ready=1 gives one byte per cycle, no bubbles.
- Byte index: 5-bit counter, increments only on transfer; at final index transfer -> FIN, tx_valid=0 next cycle, index cleared.
- busy deasserts same edge frame_done asserts; new frame possible from the cycle after FIN (needs fresh done rising edge).
- tx_ready high while tx_valid low: no effect.

Test Plan:
- Reset then A=1..9, B=9..1 via multiplier (or drive c directly: 30,24,18,84,69,54,138,114,90; cycle_count=16'h0051), pulse done, tx_ready=1 -> bytes A5,00,1E,00,18,00,12,00,54,00,45,00,36,00,8A,00,72,00,5A,00,51 on 21 consecutive cycles, tx_valid first high 2 edges after done edge, frame_done one cycle after last byte.
- Same frame, tx_ready toggled randomly (including 5-cycle stall on byte 7) -> identical byte sequence, tx_data stable during every stall, no duplicated or dropped bytes.
- done held high 100 cycles -> exactly one frame; drop done, raise again after frame_done -> second frame identical.
- Change c0 to 16'hFFFF after start mid-frame -> frame still carries 00,1E; done re-pulsed while busy -> ignored, single frame.
- rst asserted at byte 10 -> tx_valid, busy 0 next cycle; new done edge -> full frame starting at A5.
- SEND_CYCLES=0 build -> 19-byte frame ending 00,5A, frame_done follows byte 19.
